// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   - Arbiter FSM state encodings (ARB_IDLE / ARB_GRANT / ARB_SEND)
//   - Default byte width presented to uart_transmission
//   - clog2 helper for sizing counters and indices from parameters
package uart_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_GRANT = 2'd1;
   localparam logic [1:0] ARB_SEND  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ARB_IDLE,
      S_GRANT = ARB_GRANT,
      S_SEND  = ARB_SEND
   } arb_state_t;

   localparam int UART_DATA_WIDTH = 8;

   // Ceiling log2; clog2(1) = 0, so callers needing a 1-bit minimum clamp it.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   eligible : one bit per requester, 1 = may be granted
//   last     : index granted most recently; search starts at last+1
//   next     : first eligible index found, wrapping modulo NUM_REQ
//   found    : 1 when any eligible bit was set
// The previous winner is checked last, so it only wins again when it is the
// sole eligible requester.
module rr_pick
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IW      = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IW-1:0]      last,
   output logic [IW-1:0]      next,
   output logic               found
);

   always_comb begin
      int idx;
      next  = last;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         // Integer modulo keeps the wrap correct for non-power-of-2 NUM_REQ.
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            next  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a single uart_transmission.
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   req_mask/valid/last    : per-requester enable, byte valid, end-of-packet
//   req_data               : packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready              : per-requester accept (valid & ready = handshake)
//   tx_start, tx_data      : level request + byte to the transmitter
//   tx_clear               : transmitter has latched the byte
//   grant_id               : current / last granted requester
//   busy                   : FSM not idle
//   pkt_done, timeout_err  : one-cycle pulses on grant release / stall revoke
// A grant lasts one packet or MAX_PKT bytes, whichever is first. All outputs
// are registered; req_ready depends only on the FSM state, never on valid.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ      = 2,
   parameter  int DATA_WIDTH   = UART_DATA_WIDTH,
   parameter  int MAX_PKT      = 16,
   parameter  int IDLE_TIMEOUT = 1024,
   localparam int IW = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1,
   localparam int BW = clog2(MAX_PKT + 1),
   localparam int SW = (clog2(IDLE_TIMEOUT) > 0) ? clog2(IDLE_TIMEOUT) : 1
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [NUM_REQ-1:0]            req_mask,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_clear,
   output logic [IW-1:0]                 grant_id,
   output logic                          busy,
   output logic                          pkt_done,
   output logic                          timeout_err
);

   arb_state_t                           state;
   logic [BW-1:0]                        byte_cnt;
   logic [SW-1:0]                        stall_cnt;
   logic                                 last_q;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_bytes;
   logic [IW-1:0]                        pick_idx;
   logic                                 pick_found;

   assign req_bytes = req_data;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .eligible (req_valid & req_mask),
      .last     (grant_id),
      .next     (pick_idx),
      .found    (pick_found)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= S_IDLE;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         req_ready   <= '0;
         grant_id    <= IW'(NUM_REQ - 1);
         busy        <= 1'b0;
         pkt_done    <= 1'b0;
         timeout_err <= 1'b0;
         byte_cnt    <= '0;
         stall_cnt   <= '0;
         last_q      <= 1'b0;
      end else begin
         pkt_done    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  grant_id  <= pick_idx;
                  byte_cnt  <= '0;
                  stall_cnt <= '0;
                  req_ready <= NUM_REQ'(1) << pick_idx;
                  busy      <= 1'b1;
                  state     <= S_GRANT;
               end
            end
            S_GRANT: begin
               // A presented byte is taken first: ready was already high, so
               // the requester regards it as accepted even if its mask drops.
               if (req_valid[grant_id]) begin
                  tx_data   <= req_bytes[grant_id];
                  last_q    <= req_last[grant_id];
                  req_ready <= '0;
                  tx_start  <= 1'b1;
                  state     <= S_SEND;
               end else if (!req_mask[grant_id]) begin
                  req_ready <= '0;
                  busy      <= 1'b0;
                  pkt_done  <= 1'b1;
                  state     <= S_IDLE;
               end else if (stall_cnt == SW'(IDLE_TIMEOUT - 1)) begin
                  req_ready   <= '0;
                  busy        <= 1'b0;
                  pkt_done    <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else if (stall_cnt != '1) begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            S_SEND: begin
               if (tx_clear) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  tx_start <= 1'b0;
                  if (last_q || byte_cnt == BW'(MAX_PKT - 1)) begin
                     busy     <= 1'b0;
                     pkt_done <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     stall_cnt <= '0;
                     req_ready <= NUM_REQ'(1) << grant_id;
                     state     <= S_GRANT;
                  end
               end
            end
            default: begin
               req_ready <= '0;
               tx_start  <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
